// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Fetch-side program-counter controller. Each RUN cycle the PC
//             takes exactly one action chosen from the decode controls:
//             halt > ret > call > jump > branch > sequential (+1).
//             Provides the branch-target LUT index and consumes the LUT's
//             combinational target, maintains a small return stack, and
//             offers a start/done handshake to the surrounding system.
//  Ports    :
//    clk         in   1  rising-edge clock
//    reset       in   1  synchronous, active-high; overrides everything
//    start       in   1  begin/restart program (honoured in IDLE and DONE)
//    halt        in   1  decode: halt
//    jump_en     in   1  decode: unconditional jump via LUT
//    branch_en   in   1  decode: conditional branch via LUT
//    cond        in   1  branch condition flag from ALU
//    call_en     in   1  decode: call via LUT (pushes return address)
//    ret_en      in   1  decode: return (pops return address)
//    lut_idx     in   4  LUT index field from the instruction
//    lut_addr    out  4  address to the branch-target LUT (= lut_idx)
//    lut_target  in   D  target from the LUT, same cycle
//    prog_ctr    out  D  current PC
//    busy        out  1  registered: state is RUN
//    done        out  1  registered: state is DONE
//    stk_err     out  1  sticky stack overflow/underflow flag for this run
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int D       = 10,
    parameter int STACK_D = 4,
    parameter int REL     = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         halt,
    input  logic         jump_en,
    input  logic         branch_en,
    input  logic         cond,
    input  logic         call_en,
    input  logic         ret_en,
    input  logic [3:0]   lut_idx,
    output logic [3:0]   lut_addr,
    input  logic [D-1:0] lut_target,
    output logic [D-1:0] prog_ctr,
    output logic         busy,
    output logic         done,
    output logic         stk_err
);

    // Stack pointer counts 0..STACK_D inclusive, so it needs one extra code.
    localparam int c_sp_w = $clog2(STACK_D + 1);
    localparam logic [c_sp_w-1:0] c_sp_full = c_sp_w'(STACK_D);
    localparam logic [c_sp_w-1:0] c_sp_one  = c_sp_w'(1);
    localparam logic [D-1:0]      c_pc_one  = D'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [D-1:0]        r_pc;
    logic [c_sp_w-1:0]   r_sp;
    logic                r_err;
    logic                r_busy;
    logic                r_done;
    logic [D-1:0]        r_stack [STACK_D];

    // ------------------------------------------------------------------
    // Combinational next-state values
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [D-1:0]        w_pc_nxt;
    logic [c_sp_w-1:0]   w_sp_nxt;
    logic                w_err_nxt;
    logic                w_push;
    logic [D-1:0]        w_tgt;
    logic [D-1:0]        w_pc_inc;
    logic [D-1:0]        w_pop_data;

    assign w_pc_inc = r_pc + c_pc_one;

    // In relative mode the LUT holds a two's-complement offset; a plain
    // D-bit add gives the required wrap-around for negative offsets.
    if (REL != 0) begin : g_tgt_rel
        assign w_tgt = r_pc + lut_target;
    end else begin : g_tgt_abs
        assign w_tgt = lut_target;
    end

    // Top-of-stack read: entry sp-1. Nothing is selected at sp==0, and the
    // FSM never pops in that case.
    always_comb begin
        w_pop_data = '0;
        for (int i = 0; i < STACK_D; i++) begin
            if (r_sp == c_sp_w'(i + 1)) begin
                w_pop_data = r_stack[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / action decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_sp_nxt    = r_sp;
        w_err_nxt   = r_err;
        w_push      = 1'b0;

        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_sp_nxt    = '0;
                    w_err_nxt   = 1'b0;
                end
            end

            S_RUN: begin
                if (halt) begin
                    w_state_nxt = S_DONE;
                end else if (ret_en) begin
                    if (r_sp != '0) begin
                        w_pc_nxt = w_pop_data;
                        w_sp_nxt = r_sp - c_sp_one;
                    end else begin
                        // Underflow: stop with PC held.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end else if (call_en) begin
                    if (r_sp < c_sp_full) begin
                        w_push   = 1'b1;
                        w_sp_nxt = r_sp + c_sp_one;
                        w_pc_nxt = w_tgt;
                    end else begin
                        // Overflow: stop with PC held, nothing pushed.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end else if (jump_en) begin
                    w_pc_nxt = w_tgt;
                end else if (branch_en && cond) begin
                    w_pc_nxt = w_tgt;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // busy/done are decoded from the next state so they line up with the
    // state register, i.e. valid the cycle after each transition.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_sp    <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_sp    <= w_sp_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Stack storage carries no reset; validity is tracked by sp alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_D; i++) begin
            if (w_push && !reset && (r_sp == c_sp_w'(i))) begin
                r_stack[i] <= w_pc_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign lut_addr = lut_idx;
    assign prog_ctr = r_pc;
    assign busy     = r_busy;
    assign done     = r_done;
    assign stk_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Self-checking bench for pc_sequencer. Two instances (absolute
//             and relative LUT targets) share all decode inputs and one
//             branch-target LUT. A queue-based behavioural model per
//             instance predicts PC, busy, done and stk_err every cycle;
//             directed scenarios add literal expectations, followed by a
//             randomized phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int D    = 10;
    localparam int MASK = (1 << D) - 1;
    localparam int SDEP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, halt, jump_en, branch_en, cond, call_en, ret_en;
    logic [3:0]   lut_idx;
    logic [D-1:0] lut [16];

    logic [3:0]   lut_addr0, lut_addr1;
    logic [D-1:0] lut_target0, lut_target1;
    logic [D-1:0] prog_ctr0, prog_ctr1;
    logic         busy0, busy1, done0, done1, stk_err0, stk_err1;

    assign lut_target0 = lut[lut_addr0];
    assign lut_target1 = lut[lut_addr1];

    pc_sequencer #(.D(D), .STACK_D(SDEP), .REL(0)) u_abs (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .jump_en(jump_en), .branch_en(branch_en), .cond(cond),
        .call_en(call_en), .ret_en(ret_en), .lut_idx(lut_idx),
        .lut_addr(lut_addr0), .lut_target(lut_target0),
        .prog_ctr(prog_ctr0), .busy(busy0), .done(done0), .stk_err(stk_err0)
    );

    pc_sequencer #(.D(D), .STACK_D(SDEP), .REL(1)) u_rel (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .jump_en(jump_en), .branch_en(branch_en), .cond(cond),
        .call_en(call_en), .ret_en(ret_en), .lut_idx(lut_idx),
        .lut_addr(lut_addr1), .lut_target(lut_target1),
        .prog_ctr(prog_ctr1), .busy(busy1), .done(done1), .stk_err(stk_err1)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and check helper
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: mode 0=idle 1=run 2=done, stack as a queue
    // ------------------------------------------------------------------
    int mpc   [2];
    int mmode [2];
    int merr  [2];
    int stk0 [$];
    int stk1 [$];

    task automatic model_one(input int m);
        int s [$];
        int pc, md, er, tgt;
        if (m == 0) s = stk0; else s = stk1;
        pc = mpc[m]; md = mmode[m]; er = merr[m];
        if (reset) begin
            md = 0; pc = 0; er = 0; s.delete();
        end else if (md != 1) begin
            if (start) begin
                md = 1; pc = 0; er = 0; s.delete();
            end
        end else begin
            tgt = (m == 1) ? ((pc + int'(lut[lut_idx])) & MASK) : int'(lut[lut_idx]);
            if (halt) begin
                md = 2;
            end else if (ret_en) begin
                if (s.size() > 0) pc = s.pop_back();
                else begin er = 1; md = 2; end
            end else if (call_en) begin
                if (s.size() < SDEP) begin
                    s.push_back((pc + 1) & MASK);
                    pc = tgt;
                end else begin
                    er = 1; md = 2;
                end
            end else if (jump_en || (branch_en && cond)) begin
                pc = tgt;
            end else begin
                pc = (pc + 1) & MASK;
            end
        end
        mpc[m] = pc; mmode[m] = md; merr[m] = er;
        if (m == 0) stk0 = s; else stk1 = s;
    endtask

    // One clock: model consumes the same inputs the DUTs sample at the edge.
    task automatic cycle();
        @(posedge clk);
        model_one(0);
        model_one(1);
        #1;
    endtask

    task automatic clr();
        reset = 0; start = 0; halt = 0; jump_en = 0; branch_en = 0;
        cond = 0; call_en = 0; ret_en = 0; lut_idx = 4'd0;
    endtask

    // Reset, start, then n sequential cycles -> PC = n in both instances.
    task automatic restart_to(input int n);
        clr();
        reset = 1; cycle(); reset = 0;
        start = 1; cycle(); start = 0;
        repeat (n) cycle();
    endtask

    // ------------------------------------------------------------------
    // Per-cycle compare against the model, away from the active edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("abs_pc",   int'(prog_ctr0), mpc[0]);
            chk("abs_busy", int'(busy0),     int'(mmode[0] == 1));
            chk("abs_done", int'(done0),     int'(mmode[0] == 2));
            chk("abs_err",  int'(stk_err0),  merr[0]);
            chk("abs_addr", int'(lut_addr0), int'(lut_idx));
            chk("rel_pc",   int'(prog_ctr1), mpc[1]);
            chk("rel_busy", int'(busy1),     int'(mmode[1] == 1));
            chk("rel_done", int'(done1),     int'(mmode[1] == 2));
            chk("rel_err",  int'(stk_err1),  merr[1]);
            chk("rel_addr", int'(lut_addr1), int'(lut_idx));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 16; i++) lut[i] = '0;
        lut[3] = 10'd114;
        lut[5] = 10'h3FB;       // -5
        lut[6] = 10'd44;
        clr();

        reset = 1; cycle(); reset = 0;
        chk_en = 1'b1;
        chk("reset_pc",   int'(prog_ctr0), 0);
        chk("reset_busy", int'(busy0), 0);
        chk("reset_done", int'(done0), 0);

        // Start and count up.
        start = 1; cycle(); start = 0;
        chk("t1_pc0",  int'(prog_ctr0), 0);
        chk("t1_busy", int'(busy0), 1);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            chk($sformatf("t1_pc%0d", k), int'(prog_ctr0), k);
        end
        chk("t1_done", int'(done0), 0);

        // Absolute jump at PC=7.
        cycle(); cycle();
        jump_en = 1; lut_idx = 4'd3; cycle(); clr();
        chk("t2_jump_abs", int'(prog_ctr0), 114);
        chk("t2_jump_rel", int'(prog_ctr1), 121);
        cycle();
        chk("t2_seq", int'(prog_ctr0), 115);

        // Branch not taken / taken.
        restart_to(7);
        branch_en = 1; cond = 0; lut_idx = 4'd3; cycle();
        chk("t2_br_nt", int'(prog_ctr0), 8);
        cond = 1; cycle(); clr();
        chk("t2_br_t", int'(prog_ctr0), 114);

        // Relative negative offset wraps.
        restart_to(4);
        jump_en = 1; lut_idx = 4'd5; cycle(); clr();
        chk("t3_wrap_neg", int'(prog_ctr1), MASK);
        cycle();
        chk("t3_wrap_seq", int'(prog_ctr1), 0);

        // Call / return.
        restart_to(10);
        call_en = 1; lut_idx = 4'd6; cycle(); clr();
        chk("t4_call", int'(prog_ctr0), 44);
        ret_en = 1; cycle(); clr();
        chk("t4_ret_abs", int'(prog_ctr0), 11);
        chk("t4_ret_rel", int'(prog_ctr1), 11);

        // Five nested calls overflow a four-deep stack.
        restart_to(0);
        call_en = 1; lut_idx = 4'd6;
        repeat (4) cycle();
        chk("t4_nest_err", int'(stk_err0), 0);
        cycle(); clr();
        chk("t4_ovf_err",  int'(stk_err0), 1);
        chk("t4_ovf_done", int'(done0), 1);
        chk("t4_ovf_busy", int'(busy0), 0);
        chk("t4_ovf_pc",   int'(prog_ctr0), 44);
        chk("t4_ovf_pcr",  int'(prog_ctr1), 176);

        // Halt wins over jump/branch.
        restart_to(3);
        halt = 1; jump_en = 1; branch_en = 1; cond = 1; lut_idx = 4'd3;
        cycle(); clr();
        chk("t5_halt_done", int'(done0), 1);
        chk("t5_halt_pc",   int'(prog_ctr0), 3);
        cycle();
        chk("t5_held_pc",   int'(prog_ctr0), 3);

        // Underflow, then restart from DONE.
        restart_to(2);
        ret_en = 1; cycle(); clr();
        chk("t5_unf_err",  int'(stk_err0), 1);
        chk("t5_unf_done", int'(done0), 1);
        chk("t5_unf_pc",   int'(prog_ctr0), 2);
        start = 1; cycle();
        chk("t5_rs_pc",   int'(prog_ctr0), 0);
        chk("t5_rs_err",  int'(stk_err0), 0);
        chk("t5_rs_busy", int'(busy0), 1);
        cycle(); cycle(); clr();        // start held in RUN is ignored
        chk("t5_run_start", int'(prog_ctr0), 2);

        // Reset mid-RUN beats a call.
        restart_to(50);
        chk("t6_pre_pc", int'(prog_ctr0), 50);
        reset = 1; call_en = 1; lut_idx = 4'd6; cycle(); clr();
        chk("t6_pc",   int'(prog_ctr0), 0);
        chk("t6_busy", int'(busy0), 0);
        chk("t6_done", int'(done0), 0);
        chk("t6_err",  int'(stk_err0), 0);
        cycle();
        chk("t6_idle_pc", int'(prog_ctr0), 0);

        // Randomized phase.
        for (int i = 0; i < 16; i++) lut[i] = D'($urandom);
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 149) == 0);
            start     = ($urandom_range(0, 3) == 0);
            halt      = ($urandom_range(0, 39) == 0);
            ret_en    = ($urandom_range(0, 6) == 0);
            call_en   = ($urandom_range(0, 5) == 0);
            jump_en   = ($urandom_range(0, 7) == 0);
            branch_en = ($urandom_range(0, 3) == 0);
            cond      = ($urandom_range(0, 1) == 0);
            lut_idx   = 4'($urandom_range(0, 15));
            if (n % 500 == 250) lut[$urandom_range(0, 15)] = D'($urandom);
            cycle();
        end
        clr();
        @(negedge clk);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
